// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes,
// ALU/immediate encodings and datapath mux selects.
package mcu_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECR    = 4'd6;
    localparam logic [3:0] ST_EXECI    = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_JAL      = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_TRAP     = 4'd11;

    typedef enum logic [3:0] {
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_MEMADR   = ST_MEMADR,
        S_MEMREAD  = ST_MEMREAD,
        S_MEMWB    = ST_MEMWB,
        S_MEMWRITE = ST_MEMWRITE,
        S_EXECR    = ST_EXECR,
        S_EXECI    = ST_EXECI,
        S_ALUWB    = ST_ALUWB,
        S_JAL      = ST_JAL,
        S_BRANCH   = ST_BRANCH,
        S_TRAP     = ST_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_I: imm_src_of = IMM_I;
            OP_STORE:      imm_src_of = IMM_S;
            OP_BR:         imm_src_of = IMM_B;
            OP_JAL:        imm_src_of = IMM_J;
            OP_LUI:        imm_src_of = IMM_U;
            default:       imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from {funct3, funct7[5]}; I-type ops ignore funct7[5]
// because that bit belongs to the immediate there.
module alu_decoder
    import mcu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_r,
    output logic [2:0] alu_ctrl
);

    logic [3:0] key;

    always_comb begin
        key = {funct3, funct7_5 & is_r};
        case (key)
            4'b0000: alu_ctrl = ALU_ADD;
            4'b0001: alu_ctrl = ALU_SUB;
            4'b1110: alu_ctrl = ALU_AND;
            4'b1100: alu_ctrl = ALU_OR;
            4'b0100: alu_ctrl = ALU_SLT;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-sequenced control for a multi-cycle RV32I subset core sharing one memory
// port and one ALU; adds memory handshake, illegal-instruction trap and instret.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [2:0]            imm_src,
    output logic [1:0]            result_src,
    output logic                  illegal_instr,
    output logic                  retire,
    output logic [CNT_W-1:0]      instret
);

    state_t           state_reg;
    state_t           state_next;
    state_t           cur_state;
    logic [CNT_W-1:0] instret_reg;
    logic             illegal_reg;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] dec_ctrl;
    logic [2:0] alu_ctrl_raw;
    logic       is_r;
    logic       mem_req_raw, mem_write_raw, ir_write_raw, pc_write_raw;
    logic       reg_write_raw, retire_raw;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // While reset is held the outputs already show FETCH, so a reset mid-access
    // releases the memory port in the same cycle.
    assign cur_state = rst ? S_FETCH : state_reg;
    assign is_r      = (cur_state == S_EXECR);

    alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7_5 (instr[30]),
        .is_r     (is_r),
        .alu_ctrl (dec_ctrl)
    );

    always_comb begin
        state_next    = cur_state;
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        adr_src       = ADR_PC;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        alu_ctrl_raw  = ALU_ADD;
        result_src    = RES_ALUOUT;

        case (cur_state)
            S_FETCH: begin
                mem_req_raw = 1'b1;
                alu_src_b   = SRC_B_FOUR;
                result_src  = RES_ALU;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I, OP_LUI:      state_next = S_EXECI;
                    OP_BR:             state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = ADR_ALUOUT;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                result_src    = RES_RDATA;
                retire_raw    = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                mem_write_raw = 1'b1;
                adr_src       = ADR_ALUOUT;
                if (mem_ready) begin
                    retire_raw = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a    = SRC_A_RS1;
                alu_src_b    = SRC_B_RS2;
                alu_ctrl_raw = dec_ctrl;
                state_next   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b = SRC_B_IMM;
                // lui is computed as 0 + U-immediate through the same path
                if (opcode == OP_LUI) begin
                    alu_src_a    = SRC_A_ZERO;
                    alu_ctrl_raw = ALU_ADD;
                end else begin
                    alu_src_a    = SRC_A_RS1;
                    alu_ctrl_raw = dec_ctrl;
                end
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                result_src    = RES_ALUOUT;
                retire_raw    = 1'b1;
                state_next    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a    = SRC_A_OLDPC;
                alu_src_b    = SRC_B_FOUR;
                result_src   = RES_ALUOUT;
                pc_write_raw = 1'b1;
                state_next   = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a    = SRC_A_RS1;
                alu_src_b    = SRC_B_RS2;
                alu_ctrl_raw = ALU_SUB;
                result_src   = RES_ALUOUT;
                case (funct3)
                    3'b000: begin
                        pc_write_raw = zero;
                        retire_raw   = 1'b1;
                        state_next   = S_FETCH;
                    end
                    3'b001: begin
                        pc_write_raw = ~zero;
                        retire_raw   = 1'b1;
                        state_next   = S_FETCH;
                    end
                    default: state_next = S_TRAP;
                endcase
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            instret_reg <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (retire_raw) instret_reg <= instret_reg + CNT_W'(1);
            if (state_reg == S_TRAP) illegal_reg <= 1'b1;
        end
    end

    assign mem_req       = mem_req_raw   & ~rst;
    assign mem_write     = mem_write_raw & ~rst;
    assign ir_write      = ir_write_raw  & ~rst;
    assign pc_write      = pc_write_raw  & ~rst;
    assign reg_write     = reg_write_raw & ~rst;
    assign retire        = retire_raw    & ~rst;
    assign alu_ctrl      = ALU_CTRL_W'(alu_ctrl_raw);
    assign imm_src       = imm_src_of(opcode);
    assign illegal_instr = illegal_reg;
    assign instret       = instret_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with a 4-bit instret so counter
// wrap is reachable; every check is an immediate assertion.
module tb_multicycle_control_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr = 32'h0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]    alu_src_a, alu_src_b, result_src;
    logic [2:0]    alu_ctrl;
    logic [2:0]    imm_src;
    logic          illegal_instr, retire;
    logic [CW-1:0] instret;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cnt = '0;

    multicycle_control_unit #(.ALU_CTRL_W(3), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_ctrl      (alu_ctrl),
        .imm_src       (imm_src),
        .result_src    (result_src),
        .illegal_instr (illegal_instr),
        .retire        (retire),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // zero-wait FETCH then DECODE; leaves the bench one cycle into the execute state
    task automatic fetch_decode(input logic [31:0] ins, input logic [2:0] exp_imm);
        instr = ins;
        mem_ready = 1'b1;
        #1;
        chk("fetch_ir_write", ir_write, 1);
        chk("fetch_pc_write", pc_write, 1);
        cyc();
        #1;
        chk("decode_src_a", alu_src_a, 2'b01);
        chk("decode_imm_src", imm_src, exp_imm);
        chk("decode_mem_req", mem_req, 0);
        cyc();
    endtask

    task automatic retire_edge(input string tag);
        chk({tag, "_retire"}, retire, 1);
        cyc();
        exp_cnt = exp_cnt + 1'b1;
        chk({tag, "_instret"}, instret, exp_cnt);
    endtask

    task automatic exec_alu(input string tag, input logic [31:0] ins, input logic [1:0] exp_a,
                            input logic [1:0] exp_b, input logic [2:0] exp_ctrl, input logic [2:0] exp_imm);
        fetch_decode(ins, exp_imm);
        #1;
        chk({tag, "_alu_ctrl"}, alu_ctrl, exp_ctrl);
        chk({tag, "_src_a"}, alu_src_a, exp_a);
        chk({tag, "_src_b"}, alu_src_b, exp_b);
        chk({tag, "_exec_reg_write"}, reg_write, 0);
        cyc();
        #1;
        chk({tag, "_wb_reg_write"}, reg_write, 1);
        chk({tag, "_wb_result_src"}, result_src, 2'b00);
        retire_edge(tag);
        $display("txn %s instr=%08h instret=%0d", tag, ins, instret);
    endtask

    initial begin
        // reset state
        cyc();
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_instret", instret, 0);
        chk("rst_illegal", illegal_instr, 0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fetch_wait_mem_req", mem_req, 1);
            chk("fetch_wait_pc_write", pc_write, 0);
            chk("fetch_wait_ir_write", ir_write, 0);
            cyc();
        end
        $display("txn fetch wait 3 cycles");
        #1;
        chk("fetch_src_b", alu_src_b, 2'b10);
        chk("fetch_result_src", result_src, 2'b10);

        // R-type add / sub, I-type and/addi(bit30 set)/lui
        exec_alu("add",  32'h002081B3, 2'b10, 2'b00, 3'b000, 3'b000);
        exec_alu("sub",  32'h402081B3, 2'b10, 2'b00, 3'b001, 3'b000);
        exec_alu("andi", 32'h0FF0F093, 2'b10, 2'b01, 3'b010, 3'b000);
        exec_alu("addi", 32'h40000093, 2'b10, 2'b01, 3'b000, 3'b000);
        exec_alu("lui",  32'h123450B7, 2'b11, 2'b01, 3'b000, 3'b100);

        // lw with two wait cycles in MEMREAD
        fetch_decode(32'h00802283, 3'b000);
        #1;
        chk("lw_memadr_src_a", alu_src_a, 2'b10);
        chk("lw_memadr_src_b", alu_src_b, 2'b01);
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lw_memread_req", mem_req, 1);
            chk("lw_memread_adr", adr_src, 1);
            chk("lw_memread_write", mem_write, 0);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_memread_req_last", mem_req, 1);
        cyc();
        #1;
        chk("lw_memwb_reg_write", reg_write, 1);
        chk("lw_memwb_result_src", result_src, 2'b01);
        retire_edge("lw");
        $display("txn lw instret=%0d", instret);

        // sw zero-wait
        fetch_decode(32'h00502423, 3'b001);
        cyc();
        #1;
        chk("sw_mem_req", mem_req, 1);
        chk("sw_mem_write", mem_write, 1);
        chk("sw_adr_src", adr_src, 1);
        retire_edge("sw");
        $display("txn sw instret=%0d", instret);

        // beq taken, bne not taken
        zero = 1'b1;
        fetch_decode(32'h00208463, 3'b010);
        #1;
        chk("beq_pc_write", pc_write, 1);
        chk("beq_alu_ctrl", alu_ctrl, 3'b001);
        retire_edge("beq");
        $display("txn beq zero=1 instret=%0d", instret);
        fetch_decode(32'h00209463, 3'b010);
        #1;
        chk("bne_pc_write", pc_write, 0);
        retire_edge("bne");
        $display("txn bne zero=1 instret=%0d", instret);
        zero = 1'b0;

        // jal
        fetch_decode(32'h000000EF, 3'b011);
        #1;
        chk("jal_pc_write", pc_write, 1);
        chk("jal_src_a", alu_src_a, 2'b01);
        chk("jal_src_b", alu_src_b, 2'b10);
        chk("jal_retire_early", retire, 0);
        cyc();
        #1;
        chk("jal_wb_reg_write", reg_write, 1);
        retire_edge("jal");
        $display("txn jal instret=%0d", instret);

        // seven more adds: 17 retirements wrap a 4-bit counter to 1
        for (int i = 0; i < 7; i++)
            exec_alu("wrap_add", 32'h002081B3, 2'b10, 2'b00, 3'b000, 3'b000);
        chk("instret_wrap", instret, 1);

        // reset asserted during a stalled store
        fetch_decode(32'h00502423, 3'b001);
        cyc();
        mem_ready = 1'b0;
        #1;
        chk("rstw_mem_write_before", mem_write, 1);
        cyc();
        rst = 1'b1;
        #1;
        chk("rstw_mem_req_same", mem_req, 0);
        chk("rstw_mem_write_same", mem_write, 0);
        cyc();
        #1;
        chk("rstw_mem_req_next", mem_req, 0);
        chk("rstw_mem_write_next", mem_write, 0);
        chk("rstw_pc_write_next", pc_write, 0);
        chk("rstw_instret", instret, 0);
        rst = 1'b0;
        exp_cnt = '0;
        #1;
        chk("rstw_fetch_req", mem_req, 1);
        chk("rstw_fetch_adr", adr_src, 0);
        $display("txn reset during store");

        // illegal opcode -> sticky trap
        fetch_decode(32'h0000007F, 3'b000);
        cyc();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("trap_illegal", illegal_instr, 1);
            chk("trap_strobes", {mem_req, mem_write, ir_write, pc_write, reg_write, retire}, 0);
            cyc();
        end
        chk("trap_instret", instret, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("trap_cleared", illegal_instr, 0);
        chk("trap_fetch_req", mem_req, 1);
        $display("txn trap and reset recovery");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
